// File: rtl/l2_amo_ctrl_pkg.sv
// Shared types for the L2 AMO controller: line/word geometry, AMO opcodes,
// request bundle and controller state encoding.
package l2_amo_ctrl_pkg;

   localparam int unsigned WORD_BITS = 64;
   localparam int unsigned LINE_BITS = 128;

   typedef logic [WORD_BITS-1:0] word_t;
   typedef logic [LINE_BITS-1:0] line_t;
   typedef logic [0:0]           word_offset_t;
   typedef logic [2:0]           byte_offset_t;
   typedef logic [2:0]           hsize_t;
   typedef logic [5:0]           amo_t;

   localparam hsize_t WORD_32 = 3'b010;
   localparam hsize_t WORD_64 = 3'b011;

   localparam amo_t AMO_SWAP = 6'd1;
   localparam amo_t AMO_ADD  = 6'd2;
   localparam amo_t AMO_AND  = 6'd3;
   localparam amo_t AMO_OR   = 6'd4;
   localparam amo_t AMO_XOR  = 6'd5;
   localparam amo_t AMO_MAX  = 6'd6;
   localparam amo_t AMO_MAXU = 6'd7;
   localparam amo_t AMO_MIN  = 6'd8;
   localparam amo_t AMO_MINU = 6'd9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_EXEC,
      S_WRITE,
      S_RESP
   } l2_amo_state_t;

   typedef struct packed {
      word_t        word;
      word_offset_t w_off;
      byte_offset_t b_off;
      hsize_t       hsize;
      amo_t         op;
   } amo_req_t;

   // Bit offset of the addressed field inside a line; 64-bit ops are word aligned.
   function automatic logic [6:0] field_off(input word_offset_t w_off, input byte_offset_t b_off,
                                            input hsize_t hsize);
      logic [6:0] base;
      base = {w_off, 6'b000000};
      if (hsize == WORD_32) return base + 7'({b_off, 3'b000});
      return base;
   endfunction

endpackage

// File: rtl/l2_write_word_amo.sv
// Combinational AMO datapath: applies one 32/64-bit atomic op to the addressed
// field of a cache line and returns the modified line.
module l2_write_word_amo
   import l2_amo_ctrl_pkg::*;
(
   input  line_t        line_in,
   input  word_t        word,
   input  word_offset_t w_off,
   input  byte_offset_t b_off,
   input  hsize_t       hsize,
   input  amo_t         amo,
   output line_t        line_out
);

   logic       is32;
   logic [6:0] off;
   word_t      raw_old, raw_opd, mask;
   word_t      old_u, opd_u, old_s, opd_s, res;

   always_comb begin
      is32    = (hsize == WORD_32);
      off     = field_off(w_off, b_off, hsize);
      raw_old = word_t'(line_in >> off);
      // A 32-bit operand sits in the same byte lanes of the word as its target field.
      raw_opd = is32 ? (word >> {b_off, 3'b000}) : word;
      mask    = is32 ? 64'h0000_0000_FFFF_FFFF : '1;
      old_u   = raw_old & mask;
      opd_u   = raw_opd & mask;
      old_s   = is32 ? {{32{raw_old[31]}}, raw_old[31:0]} : raw_old;
      opd_s   = is32 ? {{32{raw_opd[31]}}, raw_opd[31:0]} : raw_opd;

      res = old_u;
      case (amo)
         AMO_SWAP: res = opd_u;
         AMO_ADD:  res = old_u + opd_u;
         AMO_AND:  res = old_u & opd_u;
         AMO_OR:   res = old_u | opd_u;
         AMO_XOR:  res = old_u ^ opd_u;
         AMO_MAX:  res = ($signed(old_s) > $signed(opd_s)) ? old_u : opd_u;
         AMO_MIN:  res = ($signed(old_s) < $signed(opd_s)) ? old_u : opd_u;
         AMO_MAXU: res = (old_u > opd_u) ? old_u : opd_u;
         AMO_MINU: res = (old_u < opd_u) ? old_u : opd_u;
         default:  res = old_u;
      endcase

      line_out = (line_in & ~(line_t'(mask) << off)) | (line_t'(res & mask) << off);
   end

endmodule

// File: rtl/l2_amo_ctrl.sv
// Single-outstanding AMO sequencer: read line, apply AMO, write back,
// return the pre-op value; the line address is locked while busy.
module l2_amo_ctrl
   import l2_amo_ctrl_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter int RD_LAT    = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 amo_req_valid,
   output logic                 amo_req_ready,
   input  logic [ADDR_BITS-1:0] amo_req_addr,
   input  word_t                amo_req_word,
   input  word_offset_t         amo_req_w_off,
   input  byte_offset_t         amo_req_b_off,
   input  hsize_t               amo_req_hsize,
   input  amo_t                 amo_req_op,
   output logic                 rd_en,
   output logic [ADDR_BITS-1:0] rd_addr,
   input  line_t                rd_line,
   output logic                 wr_en,
   output logic [ADDR_BITS-1:0] wr_addr,
   output line_t                wr_line,
   output logic                 amo_rsp_valid,
   input  logic                 amo_rsp_ready,
   output word_t                amo_rsp_old,
   output logic                 amo_busy,
   output logic [ADDR_BITS-1:0] amo_lock_addr
);

   localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

   l2_amo_state_t          state_q, state_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   amo_req_t               req_q, req_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   line_t                  wr_line_q, wr_line_d;
   word_t                  old_q, old_d;
   line_t                  line_out;
   word_t                  old_raw, old_ext;

   l2_write_word_amo u_amo (
      .line_in  (rd_line),
      .word     (req_q.word),
      .w_off    (req_q.w_off),
      .b_off    (req_q.b_off),
      .hsize    (req_q.hsize),
      .amo      (req_q.op),
      .line_out (line_out)
   );

   always_comb begin
      old_raw = word_t'(rd_line >> field_off(req_q.w_off, req_q.b_off, req_q.hsize));
      old_ext = (req_q.hsize == WORD_32) ? {{32{old_raw[31]}}, old_raw[31:0]} : old_raw;
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      req_d     = req_q;
      cnt_d     = cnt_q;
      wr_line_d = wr_line_q;
      old_d     = old_q;
      case (state_q)
         S_IDLE: begin
            if (amo_req_valid) begin
               addr_d  = amo_req_addr;
               req_d   = '{word: amo_req_word, w_off: amo_req_w_off, b_off: amo_req_b_off,
                           hsize: amo_req_hsize, op: amo_req_op};
               state_d = S_READ;
            end
         end
         // Data lands RD_LAT cycles after rd_en, so WAIT covers only the RD_LAT-1
         // cycles in between and EXEC is the arrival cycle.
         S_READ: begin
            if (RD_LAT == 1) begin
               state_d = S_EXEC;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_EXEC;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_EXEC: begin
            wr_line_d = line_out;
            old_d     = old_ext;
            state_d   = S_WRITE;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP: begin
            if (amo_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         req_q     <= '0;
         cnt_q     <= '0;
         wr_line_q <= '0;
         old_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         req_q     <= req_d;
         cnt_q     <= cnt_d;
         wr_line_q <= wr_line_d;
         old_q     <= old_d;
      end
   end

   always_comb begin
      amo_req_ready = rst && (state_q == S_IDLE);
      rd_en         = (state_q == S_READ);
      wr_en         = (state_q == S_WRITE);
      amo_rsp_valid = (state_q == S_RESP);
      amo_busy      = (state_q != S_IDLE);
      rd_addr       = addr_q;
      wr_addr       = addr_q;
      amo_lock_addr = amo_busy ? addr_q : '0;
      wr_line       = wr_line_q;
      amo_rsp_old   = old_q;
   end

endmodule

// File: tb/tb_l2_amo_ctrl.sv
// Scoreboard bench for l2_amo_ctrl: one instance with RD_LAT=1, one with RD_LAT=3,
// each backed by a small line-memory model with matching read latency.
module tb_l2_amo_ctrl;
   import l2_amo_ctrl_pkg::*;

   typedef struct {
      int    g;
      word_t old;
      line_t line;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid [2];
   logic         req_ready [2];
   logic [9:0]   req_addr  [2];
   word_t        req_word  [2];
   word_offset_t req_woff  [2];
   byte_offset_t req_boff  [2];
   hsize_t       req_hs    [2];
   amo_t         req_op    [2];
   logic         rd_en     [2];
   logic [9:0]   rd_addr   [2];
   line_t        rd_line   [2];
   logic         wr_en     [2];
   logic [9:0]   wr_addr   [2];
   line_t        wr_line   [2];
   logic         rsp_valid [2];
   logic         rsp_ready [2];
   word_t        rsp_old   [2];
   logic         busy      [2];
   logic [9:0]   lock_addr [2];

   logic         pl_en = 1'b0;
   int           pl_g = 0;
   logic [9:0]   pl_addr = '0;
   line_t        pl_line = '0;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;
      line_t mem  [1024];
      line_t pipe [3];

      l2_amo_ctrl #(.ADDR_BITS(10), .RD_LAT(LAT)) u_dut (
         .clk           (clk),
         .rst           (rst),
         .amo_req_valid (req_valid[g]),
         .amo_req_ready (req_ready[g]),
         .amo_req_addr  (req_addr[g]),
         .amo_req_word  (req_word[g]),
         .amo_req_w_off (req_woff[g]),
         .amo_req_b_off (req_boff[g]),
         .amo_req_hsize (req_hs[g]),
         .amo_req_op    (req_op[g]),
         .rd_en         (rd_en[g]),
         .rd_addr       (rd_addr[g]),
         .rd_line       (rd_line[g]),
         .wr_en         (wr_en[g]),
         .wr_addr       (wr_addr[g]),
         .wr_line       (wr_line[g]),
         .amo_rsp_valid (rsp_valid[g]),
         .amo_rsp_ready (rsp_ready[g]),
         .amo_rsp_old   (rsp_old[g]),
         .amo_busy      (busy[g]),
         .amo_lock_addr (lock_addr[g])
      );

      always @(posedge clk) begin
         if (pl_en && pl_g == g) mem[pl_addr] <= pl_line;
         if (wr_en[g]) mem[wr_addr[g]] <= wr_line[g];
         pipe[0] <= rd_en[g] ? mem[rd_addr[g]] : 'x;
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign rd_line[g] = pipe[LAT-1];
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] outs(input int g);
      return 256'({req_ready[g], rd_en[g], wr_en[g], rsp_valid[g], busy[g], lock_addr[g],
                   rd_addr[g], wr_addr[g], rsp_old[g], wr_line[g]});
   endfunction

   task automatic preload(input int g, input logic [9:0] a, input line_t l);
      @(negedge clk);
      pl_en = 1'b1; pl_g = g; pl_addr = a; pl_line = l;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic run_amo(input string name, input int g, input logic [9:0] addr, input word_t w,
                          input word_offset_t woff, input byte_offset_t boff, input hsize_t hs,
                          input amo_t op, input word_t eold, input line_t eline,
                          input int hold, input bit keep);
      exp_t  e;
      int    lat, cyc, rd_c, wr_c, rsp_c, nrd, nwr, nval, viol;
      bit    done;
      word_t old_seen;
      line_t line_seen;
      lat = (g == 0) ? 1 : 3;
      sb_q.push_back('{g: g, old: eold, line: eline});
      @(negedge clk);
      check({name, ":idle_busy"}, busy[g], 0);
      check({name, ":idle_ready"}, req_ready[g], 1);
      req_addr[g] = addr; req_word[g] = w; req_woff[g] = woff; req_boff[g] = boff;
      req_hs[g] = hs; req_op[g] = op; req_valid[g] = 1'b1;
      @(posedge clk); #1;
      if (!keep) req_valid[g] = 1'b0;
      cyc = 1; rd_c = -1; wr_c = -1; rsp_c = -1; nrd = 0; nwr = 0; nval = 0; viol = 0;
      done = 1'b0; old_seen = '0; line_seen = '0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (req_ready[g] !== 1'b0 || busy[g] !== 1'b1 || lock_addr[g] !== addr) viol++;
         if (32'(rd_en[g]) + 32'(wr_en[g]) + 32'(rsp_valid[g]) > 1) viol++;
         if (rd_en[g]) begin
            nrd++;
            if (rd_c < 0) rd_c = cyc;
            if (rd_addr[g] !== addr) viol++;
         end
         if (wr_en[g]) begin
            nwr++;
            if (wr_c < 0) wr_c = cyc;
            line_seen = wr_line[g];
            if (wr_addr[g] !== addr) viol++;
         end
         if (rsp_valid[g]) begin
            if (rsp_c < 0) begin
               rsp_c = cyc;
               old_seen = rsp_old[g];
            end else if (rsp_old[g] !== old_seen) begin
               viol++;
            end
            nval++;
            if (nval > hold) begin
               rsp_ready[g] = 1'b1;
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      rsp_ready[g] = 1'b0;
      check({name, ":timeout"}, done, 1);
      check({name, ":rd_cycle"}, rd_c, 1);
      check({name, ":wr_cycle"}, wr_c, 2 + lat);
      check({name, ":rsp_cycle"}, rsp_c, 3 + lat);
      check({name, ":rd_pulses"}, nrd, 1);
      check({name, ":wr_pulses"}, nwr, 1);
      check({name, ":protocol"}, viol, 0);
      if (sb_q.size() == 0) begin
         check({name, ":sb_empty"}, 1, 0);
      end else begin
         e = sb_q.pop_front();
         check({name, ":inst"}, g, e.g);
         check({name, ":rsp_old"}, old_seen, e.old);
         check({name, ":wr_line"}, line_seen, e.line);
      end
   endtask

   initial begin
      int wr_abort;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_addr[i] = '0; req_word[i] = '0; req_woff[i] = '0;
         req_boff[i] = '0; req_hs[i] = '0; req_op[i] = '0; rsp_ready[i] = 1'b0;
      end
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs0", outs(0), 0);
      check("reset_outs1", outs(1), 0);
      @(negedge clk) rst = 1'b1;

      // 1: ADD 32-bit at w_off=1, b_off=4
      preload(0, 10'h005, {32'h0000_0005, 32'hAAAA_5555, 64'h1111_2222_3333_4444});
      run_amo("add32", 0, 10'h005, {32'h3, 32'h7654_3210}, 1'b1, 3'd4, WORD_32, AMO_ADD,
              64'h5, {32'h0000_0008, 32'hAAAA_5555, 64'h1111_2222_3333_4444}, 0, 1'b0);

      // 2: SWAP 64-bit at w_off=0
      preload(0, 10'h012, {64'hCAFE_F00D_0000_0007, 64'hDEAD_BEEF_0000_0001});
      run_amo("swap64", 0, 10'h012, 64'h1234, 1'b0, 3'd0, WORD_64, AMO_SWAP,
              64'hDEAD_BEEF_0000_0001, {64'hCAFE_F00D_0000_0007, 64'h1234}, 0, 1'b0);

      // 3: signed vs unsigned max on 0xFFFF_FFFF, plus an unknown opcode
      preload(0, 10'h020, {64'h0123_4567_89AB_CDEF, 32'h7777_7777, 32'hFFFF_FFFF});
      preload(0, 10'h021, {64'h0123_4567_89AB_CDEF, 32'h7777_7777, 32'hFFFF_FFFF});
      preload(0, 10'h022, {64'h0123_4567_89AB_CDEF, 32'h7777_7777, 32'hFFFF_FFFF});
      run_amo("max32", 0, 10'h020, 64'h1, 1'b0, 3'd0, WORD_32, AMO_MAX,
              64'hFFFF_FFFF_FFFF_FFFF, {64'h0123_4567_89AB_CDEF, 32'h7777_7777, 32'h1}, 0, 1'b0);
      run_amo("maxu32", 0, 10'h021, 64'h1, 1'b0, 3'd0, WORD_32, AMO_MAXU,
              64'hFFFF_FFFF_FFFF_FFFF, {64'h0123_4567_89AB_CDEF, 32'h7777_7777, 32'hFFFF_FFFF},
              0, 1'b0);
      run_amo("unknown_op", 0, 10'h022, 64'h55, 1'b1, 3'd0, WORD_32, 6'h3F,
              64'hFFFF_FFFF_89AB_CDEF, {64'h0123_4567_89AB_CDEF, 32'h7777_7777, 32'hFFFF_FFFF},
              0, 1'b0);

      // 4: RD_LAT=3 with response held off for 5 cycles, top line address
      preload(1, 10'h3FF, {64'hF0F0_F0F0_F0F0_F0F0, 64'h5});
      run_amo("xor64_lat3", 1, 10'h3FF, 64'hFFFF_0000_FFFF_0000, 1'b1, 3'd0, WORD_64, AMO_XOR,
              64'hF0F0_F0F0_F0F0_F0F0, {64'h0F0F_F0F0_0F0F_F0F0, 64'h5}, 5, 1'b0);

      // 5: reset while waiting on the read; the aborted op must not write
      preload(1, 10'h050, {64'h100, 64'h40});
      @(negedge clk);
      req_addr[1] = 10'h050; req_word[1] = 64'h1; req_woff[1] = 1'b0; req_boff[1] = 3'd0;
      req_hs[1] = WORD_64; req_op[1] = AMO_ADD; req_valid[1] = 1'b1;
      @(posedge clk); #1 req_valid[1] = 1'b0;
      @(posedge clk); #1;
      check("abort_in_wait", busy[1], 1);
      rst = 1'b0;
      #1;
      check("abort_outs", outs(1), 0);
      wr_abort = 0;
      repeat (3) begin
         @(negedge clk);
         if (wr_en[1]) wr_abort++;
      end
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (wr_en[1] || rsp_valid[1]) wr_abort++;
      end
      check("abort_no_wr_rsp", wr_abort, 0);
      run_amo("after_reset", 1, 10'h050, 64'h2, 1'b0, 3'd0, WORD_64, AMO_ADD,
              64'h40, {64'h100, 64'h42}, 0, 1'b0);

      // 6: back-to-back on one line, request held valid across the first op
      preload(0, 10'h030, {64'h0, 64'd10});
      run_amo("b2b_first", 0, 10'h030, 64'd5, 1'b0, 3'd0, WORD_64, AMO_ADD,
              64'd10, {64'h0, 64'd15}, 0, 1'b1);
      run_amo("b2b_second", 0, 10'h030, 64'd5, 1'b0, 3'd0, WORD_64, AMO_ADD,
              64'd15, {64'h0, 64'd20}, 0, 1'b0);

      check("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
